div_controller: RTL and testbench

Multi-cycle restoring-division sequencer for the ALU. It accepts a 32-bit dividend and divisor and drives the team's 32-bit `subtractor` through one trial subtraction per cycle for 32 iterations. It returns the quotient and remainder, which the datapath writes to LO and HI respectively. It is the only user of its own `subtractor` instance; the ALU stalls on `busy`.

---
 rtl/div_controller.sv | 170 +++++++++++++++++
 tb/tb_div_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// Restoring-division sequencer with one subtractor trial per cycle.
// Signed operands are supported when the DIV_SIGNED_EN macro is defined.
module subtractor (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] difference,
  output logic        borrowOut
);
  assign {borrowOut, difference} = {1'b0, a} - {1'b0, b};
endmodule

module div_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [32:0] a_q, a_d;
  logic [31:0] q_q, q_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;

  logic [32:0] a_sh;
  logic [31:0] q_sh;
  logic [31:0] sub_diff;
  logic        sub_borrow;
  logic        a_ge_m;
  logic [31:0] q_mag, m_mag;

  assign a_sh = {a_q[31:0], q_q[31]};
  assign q_sh = {q_q[30:0], 1'b0};

  subtractor u_sub (
    .a          (a_sh[31:0]),
    .b          (m_q),
    .difference (sub_diff),
    .borrowOut  (sub_borrow)
  );

  assign a_ge_m = a_sh[32] | ~sub_borrow;

`ifdef DIV_SIGNED_EN
  assign q_mag = neg_r_q ? -q_q : q_q;
  assign m_mag = (neg_q_q ^ neg_r_q) ? -m_q : m_q;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign q_mag = q_q;
  assign m_mag = m_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d    = dividend;
          m_d    = divisor;
          quot_d = '0;
          rem_d  = '0;
          dbz_d  = 1'b0;
`ifdef DIV_SIGNED_EN
          neg_q_d = signed_op & (dividend[31] ^ divisor[31]);
          neg_r_d = signed_op & dividend[31];
`else
          neg_q_d = 1'b0;
          neg_r_d = 1'b0;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
        // Zero divisor detours through FIX so its done lands one cycle after PREP's successor.
        if (m_q == '0) begin
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = FIX;
        end else begin
          a_d     = '0;
          q_d     = q_mag;
          m_d     = m_mag;
          count_d = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        if (a_ge_m) begin
          a_d = {1'b0, sub_diff};
          q_d = {q_sh[31:1], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = q_sh;
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (!dbz_q) begin
`ifdef DIV_SIGNED_EN
          quot_d = neg_q_q ? -q_q : q_q;
          rem_d  = neg_r_q ? -a_q[31:0] : a_q[31:0];
`else
          quot_d = q_q;
          rem_d  = a_q[31:0];
`endif
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller with an expected-result queue.
module tb_div_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int unsigned total = 0;
  int unsigned bad = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;
  exp_t sbq[$];

  div_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    logic signed [31:0] na, nb;
    na = a;
    nb = b;
    e.z = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef DIV_SIGNED_EN
      if (s) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.q = 32'h8000_0000;
          e.r = 32'd0;
        end else begin
          e.q = na / nb;
          e.r = na % nb;
        end
      end
`else
      if (s && na == nb) e.q = a / b;
`endif
    end
    return e;
  endfunction

  // Drives one request; returns at the falling edge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clock);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    sbq.push_back(model(a, b, s));
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("quot_cleared", quotient, 32'd0);
    check("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
  endtask

  // k0 = number of edges already elapsed since the accepting edge.
  task automatic wait_done(input int lat, input int k0, input string tag);
    exp_t e;
    int k;
    k = k0;
    while (!done && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_quot"}, quotient, e.q);
      check({tag, "_rem"}, remainder, e.r);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.z});
    end
    @(negedge clock);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    launch(32'd100, 32'd7, 1'b0);
    wait_done(34, 0, "u100_7");
    launch(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(34, 0, "umax_1");
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(34, 0, "sm7_2");
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(34, 0, "sovf");
    launch(32'd57, 32'hFFFF_FFF8, 1'b1);
    wait_done(34, 0, "s57_m8");
    launch(32'h1234, 32'd0, 1'b0);
    wait_done(2, 0, "dbz");
    launch(32'hDEAD_BEEF, 32'h0001_0003, 1'b0);
    wait_done(34, 0, "umix");

    // A start arriving mid-division must be dropped.
    launch(32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clock);
    dividend = 32'd77;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ignored_busy", {31'd0, busy}, 32'd1);
    wait_done(34, 6, "ignore");

    // Reset mid-iteration discards the operation.
    launch(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quot", quotient, 32'd0);
    check("midrst_rem", remainder, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    void'(sbq.pop_front());
    @(negedge clock);
    check("midrst_idle", {31'd0, busy}, 32'd0);

    launch(32'd9, 32'd3, 1'b0);
    wait_done(34, 0, "u9_3");

    check("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
